// File: rtl/assign_op_pkg.sv
// assign_op_pkg: shared types and default sizes for the compound-assignment
// accumulator.
//   acc_op_e    - 4-bit command opcode (code 15 is reserved and behaves as NOP)
//   acc_state_e - controller state (IDLE accepts commands, DIV waits on divider)
package assign_op_pkg;

    localparam int ACC_WIDTH = 32;
    localparam int ACC_OPW   = 16;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LOAD = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_MUL  = 4'd4,
        OP_DIV  = 4'd5,
        OP_MOD  = 4'd6,
        OP_AND  = 4'd7,
        OP_OR   = 4'd8,
        OP_XOR  = 4'd9,
        OP_SHL  = 4'd10,
        OP_SHR  = 4'd11,
        OP_ASHL = 4'd12,
        OP_ASHR = 4'd13,
        OP_CLR  = 4'd14,
        OP_RSVD = 4'd15
    } acc_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/serial_divider.sv
// serial_divider: unsigned restoring divider, one quotient bit per clock.
//   clk, rst      - clock, synchronous active-low reset
//   start         - load dividend/divisor; iterations run on the next WIDTH edges
//   dividend      - numerator, sampled on the start edge
//   divisor       - denominator (non-zero), sampled on the start edge
//   done          - high during the cycle whose edge completes the last iteration
//   quotient      - final quotient, valid while done is high
//   remainder     - final remainder, valid while done is high
// quotient/remainder are the next-state values of the working registers, so the
// parent can capture them on the same edge that retires the last iteration.
module serial_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);

    logic             running;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q;      // dividend shifts out the top, quotient shifts in
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] d;

    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   diff;
    logic             ge;

    // Partial remainder is always < d, so 2r+1 fits in WIDTH+1 bits.
    always_comb begin
        rs        = {r, q[WIDTH-1]};
        diff      = rs - {1'b0, d};
        ge        = ~diff[WIDTH];
        quotient  = {q[WIDTH-2:0], ge};
        remainder = ge ? diff[WIDTH-1:0] : rs[WIDTH-1:0];
    end

    assign done = running && (cnt == CW'(WIDTH-1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            running <= 1'b0;
            cnt     <= '0;
            q       <= '0;
            r       <= '0;
            d       <= '0;
        end else if (start && !running) begin
            running <= 1'b1;
            cnt     <= '0;
            q       <= dividend;
            r       <= '0;
            d       <= divisor;
        end else if (running) begin
            q   <= quotient;
            r   <= remainder;
            cnt <= cnt + 1'b1;
            if (done) running <= 1'b0;
        end
    end

endmodule

// File: rtl/assign_op_accumulator.sv
// assign_op_accumulator: 32-bit register updated by a stream of compound-
// assignment commands (+= -= *= /= %= &= |= ^= <<= >>= >>>=, load, clear).
//   clk, rst     - clock, synchronous active-low reset
//   cmd_valid    - command present
//   cmd_ready    - command can be accepted (low while the divider runs)
//   cmd_op       - opcode (assign_op_pkg::acc_op_e)
//   cmd_operand  - operand, zero-extended to WIDTH
//   acc          - accumulator value
//   acc_valid    - one-cycle strobe after every completed operation
//   dz_err       - sticky divide-by-zero flag, cleared by reset or CLR
//   busy         - divider running (~cmd_ready)
module assign_op_accumulator
    import assign_op_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH,
    parameter int OPW   = ACC_OPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [OPW-1:0]   cmd_operand,
    output logic [WIDTH-1:0] acc,
    output logic             acc_valid,
    output logic             dz_err,
    output logic             busy
);
    acc_state_e       state, state_nxt;
    logic             is_mod, is_mod_nxt;
    logic [WIDTH-1:0] acc_nxt;
    logic             vld_nxt;
    logic             dz_nxt;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_q, div_r;
    logic [WIDTH-1:0] x;
    logic [4:0]       sh;
    acc_op_e          op;

    assign x         = {{(WIDTH-OPW){1'b0}}, cmd_operand};
    assign sh        = x[4:0];
    assign op        = acc_op_e'(cmd_op);
    // Ready depends only on registered state: no path from cmd_valid.
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = ~cmd_ready;

    serial_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (acc),
        .divisor   (x),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_comb begin
        state_nxt  = state;
        is_mod_nxt = is_mod;
        acc_nxt    = acc;
        vld_nxt    = 1'b0;
        dz_nxt     = dz_err;
        div_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    vld_nxt = 1'b1;
                    case (op)
                        OP_LOAD: acc_nxt = x;
                        OP_ADD:  acc_nxt = acc + x;
                        OP_SUB:  acc_nxt = acc - x;
                        OP_MUL:  acc_nxt = acc * x;
                        OP_AND:  acc_nxt = acc & x;
                        OP_OR:   acc_nxt = acc | x;
                        OP_XOR:  acc_nxt = acc ^ x;
                        OP_SHL,
                        OP_ASHL: acc_nxt = acc << sh;
                        OP_SHR:  acc_nxt = acc >> sh;
                        OP_ASHR: acc_nxt = WIDTH'($signed(acc) >>> sh);
                        OP_CLR: begin
                            acc_nxt = '0;
                            dz_nxt  = 1'b0;
                        end
                        OP_DIV,
                        OP_MOD: begin
                            if (x == '0) begin
                                // completes at once with acc untouched
                                dz_nxt = 1'b1;
                            end else begin
                                vld_nxt    = 1'b0;
                                div_start  = 1'b1;
                                is_mod_nxt = (op == OP_MOD);
                                state_nxt  = ST_DIV;
                            end
                        end
                        default: ; // NOP and reserved
                    endcase
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    acc_nxt   = is_mod ? div_r : div_q;
                    vld_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            is_mod    <= 1'b0;
            acc       <= '0;
            acc_valid <= 1'b0;
            dz_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            is_mod    <= is_mod_nxt;
            acc       <= acc_nxt;
            acc_valid <= vld_nxt;
            dz_err    <= dz_nxt;
        end
    end

endmodule

// File: tb/tb_assign_op_accumulator.sv
module tb_assign_op_accumulator;
    import assign_op_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_operand;
    logic [31:0] acc;
    logic        acc_valid;
    logic        dz_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign_op_accumulator dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .acc         (acc),
        .acc_valid   (acc_valid),
        .dz_err      (dz_err),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [15:0] opd);
        int g = 0;
        while (!cmd_ready && g < 100) begin tick(); g++; end
        if (g >= 100) chk("send_ready_timeout", {31'd0, cmd_ready}, 32'd1);
        cmd_op      = op;
        cmd_operand = opd;
        cmd_valid   = 1'b1;
        tick();
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_vld(input int maxc, output int n);
        n = 0;
        while (!acc_valid && n < maxc) begin tick(); n++; end
    endtask

    logic [3:0]  ops  [13] = '{OP_LOAD, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND,
                               OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_ASHL, OP_ASHR};
    logic [15:0] opds [13] = '{16'd10, 16'd2, 16'd2, 16'd2, 16'd2, 16'd17, 16'hFFFF,
                               16'hFFFF, 16'hAAAA, 16'd6, 16'd6, 16'd14, 16'd14};
    logic [31:0] exps [13] = '{32'd10, 32'd12, 32'd10, 32'd20, 32'd10, 32'd10, 32'd10,
                               32'h0000FFFF, 32'h00005555, 32'h00155540, 32'h00005555,
                               32'h15554000, 32'h00005555};

    initial begin
        int n;
        int pulses;
        int acc_at;
        logic rdy;

        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_operand = 16'd0;
        tick(); tick();
        chk("rst_acc",   acc, 32'd0);
        chk("rst_vld",   {31'd0, acc_valid}, 32'd0);
        chk("rst_dz",    {31'd0, dz_err}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        rst = 1'b1;
        tick();

        // operation chain
        for (int i = 0; i < 13; i++) begin
            send(ops[i], opds[i]);
            if (ops[i] == OP_DIV || ops[i] == OP_MOD) begin
                chk($sformatf("chain%0d_busy", i), {31'd0, busy}, 32'd1);
                chk($sformatf("chain%0d_hold", i), acc, exps[i-1]);
                wait_vld(40, n);
                chk($sformatf("chain%0d_lat", i), n, 32'd32);
                chk($sformatf("chain%0d_rdy", i), {31'd0, cmd_ready}, 32'd1);
            end else begin
                chk($sformatf("chain%0d_vld", i), {31'd0, acc_valid}, 32'd1);
            end
            chk($sformatf("chain%0d_acc", i), acc, exps[i]);
        end
        tick();
        chk("vld_one_cycle", {31'd0, acc_valid}, 32'd0);

        // sign handling
        send(OP_LOAD, 16'h8000); send(OP_SHL, 16'd16);
        chk("shl16", acc, 32'h80000000);
        send(OP_ASHR, 16'd4);
        chk("ashr4", acc, 32'hF8000000);
        send(OP_LOAD, 16'h8000); send(OP_SHL, 16'd16); send(OP_SHR, 16'd4);
        chk("shr4", acc, 32'h08000000);

        // divide by zero
        send(OP_LOAD, 16'd7); send(OP_DIV, 16'd0);
        chk("dz_acc",   acc, 32'd7);
        chk("dz_flag",  {31'd0, dz_err}, 32'd1);
        chk("dz_vld",   {31'd0, acc_valid}, 32'd1);
        chk("dz_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        chk("dz_ready2", {31'd0, cmd_ready}, 32'd1);
        send(OP_NOP, 16'd0);
        chk("dz_sticky", {31'd0, dz_err}, 32'd1);
        send(OP_CLR, 16'd0);
        chk("clr_acc", acc, 32'd0);
        chk("clr_dz",  {31'd0, dz_err}, 32'd0);

        // backpressure: ADD 1 waits behind DIV 3
        send(OP_LOAD, 16'd100); send(OP_DIV, 16'd3);
        cmd_op = OP_ADD; cmd_operand = 16'd1; cmd_valid = 1'b1;
        pulses = 0; acc_at = 0;
        for (int k = 1; k <= 60 && cmd_valid; k++) begin
            rdy = cmd_ready;
            tick();
            if (acc_valid) pulses++;
            if (k == 20) chk("bp_hold", acc, 32'd100);
            if (rdy) begin cmd_valid = 1'b0; acc_at = k; end
        end
        cmd_valid = 1'b0;
        repeat (3) begin tick(); if (acc_valid) pulses++; end
        chk("bp_accept_edge", acc_at, 32'd33);
        chk("bp_pulses", pulses, 32'd2);
        chk("bp_acc", acc, 32'd34);

        // reset in the middle of a divide
        send(OP_LOAD, 16'hFFFF); send(OP_DIV, 16'd5);
        repeat (9) tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mr_acc",   acc, 32'd0);
        chk("mr_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mr_vld",   {31'd0, acc_valid}, 32'd0);
        chk("mr_dz",    {31'd0, dz_err}, 32'd0);
        cmd_op = OP_LOAD; cmd_operand = 16'd3; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("mr_load_acc", acc, 32'd3);
        chk("mr_load_vld", {31'd0, acc_valid}, 32'd1);
        pulses = 0;
        repeat (35) begin tick(); if (acc_valid) pulses++; end
        chk("mr_no_stray", pulses, 32'd0);
        chk("mr_acc_kept", acc, 32'd3);

        // reserved opcode
        send(OP_RSVD, 16'h1234);
        chk("rsvd_acc", acc, 32'd3);
        chk("rsvd_vld", {31'd0, acc_valid}, 32'd1);
        tick();
        chk("rsvd_vld_drop", {31'd0, acc_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/assign_op_accumulator.md
# assign_op_accumulator

Command-driven 32-bit accumulator that applies a stream of compound-assignment operations (add, subtract, multiply, divide, modulo, bitwise, logical and arithmetic shifts) to a held register. It is the stage feeding the accumulator word `acc` to downstream logic. Commands arrive over a valid/ready handshake and every completed operation is reported with a one-cycle strobe. Divide and modulo run on an iterative divider; all other operations complete in one cycle.

## Interface
- `WIDTH`, 32: accumulator width.
- `OPW`, 16: command operand width. The operand is zero-extended to `WIDTH`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 4: opcode, enumerated in the package.
- `cmd_operand` in `OPW`: operand.
- `acc` out `WIDTH`: accumulator value.
- `acc_valid` out 1: one-cycle strobe, "operation just completed, `acc` is current".
- `dz_err` out 1: sticky divide-by-zero flag.
- `busy` out 1: high while the divider is running. Always equals `~cmd_ready`.

## Operation
- A command is accepted on a rising edge where `cmd_valid & cmd_ready`. Call that edge N.
- Opcodes: 0 NOP, 1 LOAD, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 MOD, 7 AND, 8 OR, 9 XOR, 10 SHL, 11 SHR, 12 ASHL, 13 ASHR, 14 CLR. Code 15 is reserved and behaves as NOP.
- Let `x` be the zero-extended operand. Results:
  - LOAD: `acc = x`.
  - ADD, SUB: modulo 2^`WIDTH`.
  - MUL: low `WIDTH` bits of the product.
  - DIV, MOD: unsigned.
  - Shifts: amount `x[4:0]`. SHR fills with zeros. ASHR replicates `acc[WIDTH-1]`. ASHL is identical to SHL.
  - CLR: `acc = 0` and `dz_err = 0`.
- Single-cycle ops write `acc` at edge N.
- DIV/MOD with `x != 0`:
  - State machine IDLE → DIV → IDLE.
  - Restoring divide, one quotient bit per cycle, `WIDTH` iterations on edges N+1..N+32.
  - Quotient (DIV) or remainder (MOD) written to `acc` at edge N+32.
  - Dividend is `acc` sampled at edge N.
- DIV/MOD with `x == 0`:
  - Single-cycle.
  - `acc` unchanged.
  - `dz_err` set at edge N and stays set until reset or CLR.
  - No DIV state.
- States:
  - IDLE: `cmd_ready = 1`.
  - DIV: `cmd_ready = 0`, 5-bit iteration counter 0..31; leaves on count 31.
- Boundary conditions:
  - Reserved opcode and NOP: `acc` unchanged, `acc_valid` still pulses.
  - `cmd_valid` held high during DIV: the command is not consumed. The sender keeps `cmd_op`/`cmd_operand` stable until accepted.
  - Reset (`rst = 0`) in any state, including mid-divide: at the next edge, abort, go to IDLE, `acc = 0`, `dz_err = 0`, `acc_valid = 0`, counter = 0.
- Reset values: `acc` 0, `acc_valid` 0, `dz_err` 0, `cmd_ready` 1, `busy` 0.

## Timing
- Single-cycle ops:
  - `acc` and `acc_valid` are registered and visible in the cycle after edge N.
  - `acc_valid` is high for exactly that one cycle.
  - Back-to-back acceptance every cycle is supported, giving one `acc_valid` per cycle.
- DIV/MOD (`x != 0`):
  - `cmd_ready` is low in the cycles after edges N..N+31 and returns high after edge N+32.
  - `acc_valid` is high in the cycle after edge N+32.
  - The next command can be accepted at edge N+33.
- `acc` holds its value between updates. During a divide, `acc` keeps the pre-divide value until edge N+32.
- No combinational path from `cmd_valid` to `cmd_ready`.

## Structure
- Package `assign_op_pkg` holds:
  - `acc_op_e` enum (4-bit, codes above).
  - `acc_state_e` (IDLE, DIV).
  - Default `WIDTH`/`OPW` localparams.
- Sub-module `serial_divider`:
  - Unsigned restoring divider with `start`, dividend, divisor, `done`, quotient and remainder.
  - Same clock and synchronous active-low reset.
  - The parent selects quotient or remainder.
- All other logic lives in the top module as one `always_ff` for state and registers, plus one `always_comb` for the next-value ALU.

## Test plan
- Chain LOAD 10 → ADD 2 → SUB 2 → MUL 2 → DIV 2 → MOD 17 → AND FFFF → OR FFFF → XOR AAAA → SHL 6 → SHR 6 → ASHL 14 → ASHR 14.
  - Required `acc` values in order: 10, 12, 10, 20, 10, 10, 10, 0xFFFF, 0x5555, 0x155540, 0x5555, 0x15554000, 0x5555.
  - DIV and MOD each show `acc_valid` 33 cycles after acceptance; all others 1 cycle after.
- Sign handling:
  - LOAD 0x8000, SHL 16 → 0x80000000.
  - ASHR 4 → 0xF8000000.
  - LOAD 0x8000, SHL 16, SHR 4 → 0x08000000.
- Divide by zero:
  - LOAD 7, DIV 0 → `acc` 7, `dz_err` 1 after 1 cycle, `cmd_ready` never drops.
  - Then CLR → `acc` 0, `dz_err` 0.
- Backpressure:
  - LOAD 100, DIV 3 with `cmd_valid` held high carrying ADD 1.
  - ADD is not accepted until `cmd_ready` rises.
  - Final `acc` is 34 (33 + 1); exactly two `acc_valid` pulses after the LOAD.
- Reset mid-divide:
  - LOAD 0xFFFF, DIV 5, assert `rst` low for one cycle at iteration 10.
  - Required: `acc` 0, `cmd_ready` 1, no `acc_valid`.
  - A new LOAD 3 is accepted on the first edge after reset release.
- Reserved opcode 15 with operand 0x1234 → `acc` unchanged, one `acc_valid` pulse.
